// File: rtl/comparador_pkg.sv
// Shared types for the serial magnitude comparator.
//   state_e  : controller states (idle, digit-by-digit compare, one-cycle done)
//   result_e : encoding of the sticky partial result; ResEq means "no digit has differed yet"
package comparador_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCompare = 2'd1,
        StDone    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ResEq = 2'd0,
        ResGt = 2'd1,
        ResLt = 2'd2
    } result_e;

    // Fold a digit comparator's gt/lt pair into the result encoding.
    function automatic result_e digit_result(input logic gt, input logic lt);
        if (gt) begin
            return ResGt;
        end else if (lt) begin
            return ResLt;
        end
        return ResEq;
    endfunction

endpackage

// File: rtl/comparador_serial_if.sv
// Request/result bundle of the serial comparator.
//   start, signed_mode, A, B : request side, driven by the master
//   busy, done, G, L, E      : status and registered result, driven by the comparator
interface comparador_serial_if #(
    parameter int unsigned W = 8
);
    logic         start;
    logic         signed_mode;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         G;
    logic         L;
    logic         E;

    modport master (
        output start, signed_mode, A, B,
        input  busy, done, G, L, E
    );

    modport slave (
        input  start, signed_mode, A, B,
        output busy, done, G, L, E
    );
endinterface

// File: rtl/comparador_digito.sv
// Combinational unsigned magnitude comparator for one D-bit digit.
//   a_i, b_i : digit operands
//   gt_o     : a_i > b_i
//   lt_o     : a_i < b_i
//   eq_o     : a_i == b_i
module comparador_digito #(
    parameter int unsigned D = 1
) (
    input  logic [D-1:0] a_i,
    input  logic [D-1:0] b_i,
    output logic         gt_o,
    output logic         lt_o,
    output logic         eq_o
);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);
    assign eq_o = (a_i == b_i);
endmodule

// File: rtl/comparador_serial.sv
// Serial MSB-first magnitude comparator, D bits per clock, unsigned or two's complement.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of comparador_serial_if
//           start/signed_mode/A/B captured in idle; busy during compare;
//           done one-cycle pulse; G/L/E registered, held until the next done
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter int unsigned D          = 1,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    comparador_serial_if.slave  bus
);
    localparam int unsigned NumDig = W / D;
    localparam int unsigned CntW   = (NumDig > 1) ? $clog2(NumDig) : 1;
    // Flipping the sign bit of both operands turns two's complement into offset binary,
    // so the unsigned digit compare orders signed values correctly.
    localparam logic [W-1:0] MsbMask = {1'b1, {(W - 1){1'b0}}};

    state_e          state_q;
    logic [W-1:0]    sa_q;
    logic [W-1:0]    sb_q;
    logic [CntW-1:0] cnt_q;
    result_e         sticky_q;
    logic            busy_q;
    logic            done_q;
    logic            g_q;
    logic            l_q;
    logic            e_q;

    logic            dig_gt;
    logic            dig_lt;
    logic            dig_eq;
    result_e         merged_res;

    comparador_digito #(
        .D (D)
    ) u_digito (
        .a_i  (sa_q[W-1 -: D]),
        .b_i  (sb_q[W-1 -: D]),
        .gt_o (dig_gt),
        .lt_o (dig_lt),
        .eq_o (dig_eq)
    );

    // The first differing digit decides; later digits never override it.
    always_comb begin
        merged_res = sticky_q;
        if (sticky_q == ResEq) begin
            merged_res = digit_result(dig_gt, dig_lt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            sticky_q <= ResEq;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            g_q      <= 1'b0;
            l_q      <= 1'b0;
            e_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        sa_q     <= bus.signed_mode ? (bus.A ^ MsbMask) : bus.A;
                        sb_q     <= bus.signed_mode ? (bus.B ^ MsbMask) : bus.B;
                        cnt_q    <= CntW'(NumDig - 1);
                        sticky_q <= ResEq;
                        busy_q   <= 1'b1;
                        state_q  <= StCompare;
                    end
                end
                StCompare: begin
                    if (EARLY_EXIT && !dig_eq) begin
                        g_q     <= dig_gt;
                        l_q     <= dig_lt;
                        e_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (cnt_q == '0) begin
                        g_q     <= (merged_res == ResGt);
                        l_q     <= (merged_res == ResLt);
                        e_q     <= (merged_res == ResEq);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        sticky_q <= merged_res;
                        sa_q     <= sa_q << D;
                        sb_q     <= sb_q << D;
                        cnt_q    <= cnt_q - CntW'(1);
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.G    = g_q;
    assign bus.L    = l_q;
    assign bus.E    = e_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Directed bench for comparador_serial: three instances (W=8/D=1 early exit,
// W=16/D=4 full length, W=16/D=4 early exit) driven from one initial block,
// with expected results queued on start and popped on done.
module tb_comparador_serial;

    typedef struct {
        string      tag;
        logic [2:0] gle;
        int         lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   sel;
    int   n_vec;
    int   n_mis;
    logic [4:0] obs;          // {busy, done, G, L, E} of the selected instance
    logic [2:0] last_gle [3];
    exp_t scoreboard [$];

    comparador_serial_if #(.W(8))  bus8 ();
    comparador_serial_if #(.W(16)) bus16n ();
    comparador_serial_if #(.W(16)) bus16e ();

    comparador_serial #(.W(8), .D(1), .EARLY_EXIT(1'b1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    comparador_serial #(.W(16), .D(4), .EARLY_EXIT(1'b0)) u_dut16n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16n)
    );

    comparador_serial #(.W(16), .D(4), .EARLY_EXIT(1'b1)) u_dut16e (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16e)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            0:       obs = {bus8.busy, bus8.done, bus8.G, bus8.L, bus8.E};
            1:       obs = {bus16n.busy, bus16n.done, bus16n.G, bus16n.L, bus16n.E};
            default: obs = {bus16e.busy, bus16e.done, bus16e.G, bus16e.L, bus16e.E};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: arithmetic compare of the (optionally signed) values; latency from
    // the position of the first differing digit.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sm,
                                  input int w, input int d, input bit ee,
                                  output logic [2:0] gle, output int lat);
        int va, vb, da, db;
        bit found;
        va = int'(a) & ((1 << w) - 1);
        vb = int'(b) & ((1 << w) - 1);
        if (sm && va >= (1 << (w - 1))) va -= (1 << w);
        if (sm && vb >= (1 << (w - 1))) vb -= (1 << w);
        gle = (va > vb) ? 3'b100 : ((va < vb) ? 3'b010 : 3'b001);
        lat = w / d;
        found = 1'b0;
        if (ee) begin
            for (int i = 0; i < w / d; i++) begin
                da = (int'(a) >> (w - d * (i + 1))) & ((1 << d) - 1);
                db = (int'(b) >> (w - d * (i + 1))) & ((1 << d) - 1);
                if (!found && da != db) begin
                    lat = i + 1;
                    found = 1'b1;
                end
            end
        end
    endfunction

    task automatic drive(input int s, input logic st, input logic sm,
                         input logic [15:0] a, input logic [15:0] b);
        case (s)
            0: begin
                bus8.start = st; bus8.signed_mode = sm; bus8.A = a[7:0]; bus8.B = b[7:0];
            end
            1: begin
                bus16n.start = st; bus16n.signed_mode = sm; bus16n.A = a; bus16n.B = b;
            end
            default: begin
                bus16e.start = st; bus16e.signed_mode = sm; bus16e.A = a; bus16e.B = b;
            end
        endcase
    endtask

    // One comparison on instance s. With hold=1, start stays high through DONE and
    // the operands/mode are scrambled right after capture.
    task automatic run_cmp(input int s, input logic [15:0] a, input logic [15:0] b,
                           input logic sm, input bit hold, input string tag);
        int   w, d, n, busy_cnt;
        bit   ee;
        exp_t x, e;
        case (s)
            0:       begin w = 8;  d = 1; ee = 1'b1; end
            1:       begin w = 16; d = 4; ee = 1'b0; end
            default: begin w = 16; d = 4; ee = 1'b1; end
        endcase
        sel = s;
        x.tag = tag;
        model(a, b, sm, w, d, ee, x.gle, x.lat);
        scoreboard.push_back(x);

        @(negedge clk);
        drive(s, 1'b1, sm, a, b);
        @(posedge clk);
        @(negedge clk);
        if (hold) drive(s, 1'b1, ~sm, ~a, ~b);
        else      drive(s, 1'b0, sm, a, b);
        chk({tag, "_held"}, 32'(obs[2:0]), 32'(last_gle[s]));
        busy_cnt = int'(obs[4]);
        n = 0;
        while (!obs[3] && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!obs[3]) busy_cnt += int'(obs[4]);
        end
        e = scoreboard.pop_front();
        chk({e.tag, "_done"}, 32'(obs[3]), 32'd1);
        chk({e.tag, "_lat"}, n, e.lat);
        chk({e.tag, "_gle"}, 32'(obs[2:0]), 32'(e.gle));
        chk({e.tag, "_busycyc"}, busy_cnt, e.lat);
        chk({e.tag, "_busyoff"}, 32'(obs[4]), 32'd0);
        last_gle[s] = e.gle;

        @(negedge clk);
        chk({e.tag, "_pulse"}, 32'(obs[4:3]), 32'd0);
        drive(s, 1'b0, sm, a, b);
        @(negedge clk);
        chk({e.tag, "_norestart"}, 32'(obs[4:3]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        sel   = 0;
        n_vec = 0;
        n_mis = 0;
        for (int i = 0; i < 3; i++) last_gle[i] = 3'b000;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(2, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("reset_state%0d", s), 32'(obs), 32'd0);
        end

        run_cmp(0, 16'h0080, 16'h0080, 1'b0, 1'b0, "u8_eq80");
        run_cmp(0, 16'h00C0, 16'h0080, 1'b0, 1'b0, "u8_gtC0");
        run_cmp(0, 16'h0080, 16'h00C0, 1'b0, 1'b0, "u8_lt80");
        run_cmp(0, 16'h0080, 16'h007F, 1'b1, 1'b0, "s8_neg");
        run_cmp(0, 16'h00C0, 16'h0080, 1'b0, 1'b1, "u8_hold");
        run_cmp(0, 16'h0080, 16'h007F, 1'b0, 1'b0, "u8_msb");
        run_cmp(0, 16'h00FF, 16'h00FE, 1'b1, 1'b0, "s8_lsb");

        run_cmp(1, 16'h1243, 16'h1234, 1'b0, 1'b0, "w16_full_gt");
        run_cmp(1, 16'h8000, 16'h0001, 1'b1, 1'b0, "w16_full_sneg");
        run_cmp(1, 16'hABCD, 16'hABCD, 1'b0, 1'b0, "w16_full_eq");
        run_cmp(2, 16'h1243, 16'h1234, 1'b0, 1'b0, "w16_ee_gt");
        run_cmp(2, 16'hFFFF, 16'h0001, 1'b1, 1'b0, "w16_ee_sneg");
        run_cmp(2, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, "w16_ee_eq");

        // Reset in the third compare cycle of an 8-cycle comparison.
        sel = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h0055, 16'h0055);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0055, 16'h0055);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_abort", 32'(obs), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) last_gle[i] = 3'b000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("rst_nodone%0d", i), 32'(obs), 32'd0);
        end
        run_cmp(0, 16'h0001, 16'h0002, 1'b0, 1'b0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
